// File: rtl/vga_frame_engine.sv
// VGA raster engine: timing counters, pixel coordinates and linear address, and a
// frame-boundary mode latch. Colour and syncs are aligned through a PIPE_LAT-deep delay line.
module vga_frame_engine #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned NUM_MODES = 4,
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned PIPE_LAT  = 2,
    parameter int unsigned MSEL_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                          iVGA_CLK,
    input  logic                          iRST_n,
    input  logic [MSEL_W-1:0]             iMode,
    input  logic [NUM_MODES*ADDR_W-1:0]   iAddr_bus,
    input  logic [NUM_MODES*24-1:0]       iRGB_bus,
    output logic [ADDR_W-1:0]             oPixAddr,
    output logic [15:0]                   oPixX,
    output logic [15:0]                   oPixY,
    output logic [ADDR_W-1:0]             oAddr,
    output logic [MSEL_W-1:0]             oMode,
    output logic                          oMode_err,
    output logic                          oFrame_start,
    output logic [15:0]                   oFrame_cnt,
    output logic                          oHS,
    output logic                          oVS,
    output logic                          oBLANK_n,
    output logic [7:0]                    b_data,
    output logic [7:0]                    g_data,
    output logic [7:0]                    r_data
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    typedef struct packed {
        logic              active;
        logic              hs;
        logic              vs;
        logic [MSEL_W-1:0] mode;
    } pipe_t;

    logic              run_q, run_d;
    logic [15:0]       h_q, h_d, v_q, v_d;
    logic [ADDR_W-1:0] pix_q, pix_d;
    logic [MSEL_W-1:0] mode_q, mode_d;
    logic              err_q, err_d;
    logic              fs_q, fs_d;
    logic [15:0]       fcnt_q, fcnt_d;
    pipe_t             pipe_q [PIPE_LAT];
    pipe_t             pipe_d [PIPE_LAT];
    logic              hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic [23:0]       rgb_q, rgb_d;
    logic [23:0]       rgb_sel_c;
    logic [ADDR_W-1:0] addr_c;
    pipe_t             raw_c;

    // Raster decode of the current counter position
    always_comb begin
        raw_c        = '0;
        raw_c.active = (h_q < 16'(H_ACTIVE)) && (v_q < 16'(V_ACTIVE));
        raw_c.hs     = (h_q >= 16'(HS_BEG)) && (h_q < 16'(HS_END));
        raw_c.vs     = (v_q >= 16'(VS_BEG)) && (v_q < 16'(VS_END));
        raw_c.mode   = mode_q;
    end

    // Channel muxes: address by active mode, colour by the delayed mode
    always_comb begin
        addr_c    = '0;
        rgb_sel_c = '0;
        for (int unsigned k = 0; k < NUM_MODES; k++) begin
            if (mode_q == MSEL_W'(k)) begin
                addr_c = iAddr_bus[k*ADDR_W +: ADDR_W];
            end
            if (pipe_q[PIPE_LAT-1].mode == MSEL_W'(k)) begin
                rgb_sel_c = iRGB_bus[k*24 +: 24];
            end
        end
    end

    // run_q holds the raster at 0,0 for one clock after reset so frame_start is seen there
    always_comb begin
        run_d     = 1'b1;
        h_d       = h_q;
        v_d       = v_q;
        pix_d     = pix_q;
        mode_d    = mode_q;
        err_d     = err_q;
        fcnt_d    = fcnt_q;
        pipe_d    = pipe_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;
        rgb_d     = rgb_q;

        if (run_q) begin
            if (h_q == 16'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == 16'(V_TOTAL - 1)) ? 16'd0 : v_q + 16'd1;
            end else begin
                h_d = h_q + 16'd1;
            end
            pipe_d[0] = raw_c;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
            hs_d      = pipe_q[PIPE_LAT-1].hs ? HS_POL : ~HS_POL;
            vs_d      = pipe_q[PIPE_LAT-1].vs ? VS_POL : ~VS_POL;
            blank_n_d = pipe_q[PIPE_LAT-1].active;
            rgb_d     = pipe_q[PIPE_LAT-1].active ? rgb_sel_c : 24'd0;
            if ((h_d == 16'd0) && (v_d == 16'(V_ACTIVE))) begin
                if (32'(iMode) < NUM_MODES) begin
                    mode_d = iMode;
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        fs_d = (h_d == 16'd0) && (v_d == 16'd0);
        if (fs_d && run_q) begin
            fcnt_d = fcnt_q + 16'd1;
        end
        if (fs_d) begin
            pix_d = '0;
        end else if ((h_d < 16'(H_ACTIVE)) && (v_d < 16'(V_ACTIVE))) begin
            pix_d = pix_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            run_q     <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            pix_q     <= '0;
            mode_q    <= '0;
            err_q     <= 1'b0;
            fs_q      <= 1'b0;
            fcnt_q    <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            run_q     <= run_d;
            h_q       <= h_d;
            v_q       <= v_d;
            pix_q     <= pix_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            fs_q      <= fs_d;
            fcnt_q    <= fcnt_d;
            pipe_q    <= pipe_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
            rgb_q     <= rgb_d;
        end
    end

    assign oPixAddr     = pix_q;
    assign oPixX        = h_q;
    assign oPixY        = v_q;
    assign oAddr        = addr_c;
    assign oMode        = mode_q;
    assign oMode_err    = err_q;
    assign oFrame_start = fs_q;
    assign oFrame_cnt   = fcnt_q;
    assign oHS          = hs_q;
    assign oVS          = vs_q;
    assign oBLANK_n     = blank_n_q;
    assign b_data       = rgb_q[23:16];
    assign g_data       = rgb_q[15:8];
    assign r_data       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_frame_engine.sv
// Scoreboard bench for vga_frame_engine on a 14x7 raster (8x4 visible), four mode channels.
module tb_vga_frame_engine;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned MW = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [MW-1:0]    mode_in;
    logic [NM*AW-1:0] addr_bus;
    logic [NM*24-1:0] rgb_bus;
    logic [AW-1:0]    pix_addr, addr_out;
    logic [15:0]      pix_x, pix_y, frame_cnt;
    logic [MW-1:0]    mode_out;
    logic             mode_err, frame_start, hs, vs, blank_n;
    logic [7:0]       b_d, g_d, r_d;

    always #5 clk = ~clk;

    vga_frame_engine #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .NUM_MODES(NM), .ADDR_W(AW), .PIPE_LAT(2), .MSEL_W(MW)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iMode(mode_in),
        .iAddr_bus(addr_bus), .iRGB_bus(rgb_bus),
        .oPixAddr(pix_addr), .oPixX(pix_x), .oPixY(pix_y), .oAddr(addr_out),
        .oMode(mode_out), .oMode_err(mode_err), .oFrame_start(frame_start),
        .oFrame_cnt(frame_cnt), .oHS(hs), .oVS(vs), .oBLANK_n(blank_n),
        .b_data(b_d), .g_data(g_d), .r_data(r_d)
    );

    typedef struct packed {
        logic [15:0]   x;
        logic [15:0]   y;
        logic [AW-1:0] pix;
        logic [AW-1:0] addr;
        logic [MW-1:0] mode;
        logic          err;
        logic          fs;
        logic [15:0]   fcnt;
        logic          hs;
        logic          vs;
        logic          bn;
        logic [23:0]   rgb;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_cmp   = 0;
    int    n_bad   = 0;
    int    fs_seen = 0;
    int    mode_hist [1024];
    logic  err_hist  [1024];

    function automatic int hpos(int n);
        return n % 14;
    endfunction

    function automatic int vpos(int n);
        return (n / 14) % 7;
    endfunction

    // Visible pixels count up; blanking holds the last visible address of that line/frame
    function automatic int pix_exp(int n);
        int h;
        int v;
        h = hpos(n);
        v = vpos(n);
        if (h < 8 && v < 4) return v * 8 + h;
        if (v < 4) return v * 8 + 7;
        return 31;
    endfunction

    function automatic logic [7:0] addr_k(int k, int n);
        return 8'(pix_exp(n) + 40 * k);
    endfunction

    function automatic logic [23:0] colour(int k, logic [7:0] a);
        return {8'(16 * k + 1), 8'(90 ^ k), a};
    endfunction

    function automatic obs_t exp_reset();
        obs_t e;
        e      = '0;
        e.addr = 8'h80;
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        return e;
    endfunction

    function automatic obs_t exp_run(int n);
        obs_t e;
        int   m;
        int   hp;
        int   vp;
        e      = '0;
        e.x    = 16'(hpos(n));
        e.y    = 16'(vpos(n));
        e.pix  = 8'(pix_exp(n));
        e.addr = addr_k(mode_hist[n], n);
        e.mode = 3'(mode_hist[n]);
        e.err  = err_hist[n];
        e.fs   = (hpos(n) == 0) && (vpos(n) == 0);
        e.fcnt = 16'(n / 98);
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        if (n >= 3) begin
            m     = n - 3;
            hp    = hpos(m);
            vp    = vpos(m);
            e.hs  = !(hp >= 10 && hp < 12);
            e.vs  = (vp != 5);
            e.bn  = (hp < 8) && (vp < 4);
            e.rgb = e.bn ? colour(mode_hist[m], addr_k(mode_hist[m], m)) : 24'd0;
        end
        return e;
    endfunction

    task automatic drive_reset_pattern();
        for (int k = 0; k < NM; k++) begin
            addr_bus[k*AW +: AW] = 8'(128 + k);
            rgb_bus[k*24 +: 24]  = 24'hFFFFFF;
        end
    endtask

    // Emulates per-mode memories returning colour two clocks after the address
    task automatic drive_run(int n);
        for (int k = 0; k < NM; k++) begin
            addr_bus[k*AW +: AW] = addr_k(k, n);
            rgb_bus[k*24 +: 24]  = colour(k, (n >= 2) ? addr_k(k, n - 2) : 8'h00);
        end
    endtask

    function automatic logic [MW-1:0] sched(int ph, int n);
        if (ph == 1) return 3'd2;
        if (n < 14)  return 3'd0;
        if (n < 98)  return 3'd2;
        if (n < 210) return 3'd1;
        if (n < 260) return 3'd5;
        return 3'd3;
    endfunction

    task automatic push_reset(string t);
        exp_q.push_back(exp_reset());
        tag_q.push_back(t);
    endtask

    task automatic run_phase(int ph, int len);
        int   cur_mode;
        logic cur_err;
        cur_mode = 0;
        cur_err  = 1'b0;
        for (int n = 0; n < len; n++) begin
            @(posedge clk);
            #1;
            mode_in = sched(ph, n);
            drive_run(n);
            mode_hist[n] = cur_mode;
            err_hist[n]  = cur_err;
            exp_q.push_back(exp_run(n));
            tag_q.push_back($sformatf("ph%0d_n%0d", ph, n));
            if (hpos(n) == 13 && vpos(n) == 3) begin
                if (mode_in < 3'd4) cur_mode = int'(mode_in);
                else                cur_err  = 1'b1;
            end
        end
    endtask

    // Monitor: the engine presents a raster sample every clock
    always @(negedge clk) begin
        obs_t  a;
        obs_t  e;
        string t;
        if (frame_start === 1'b1) fs_seen++;
        if (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            t      = tag_q.pop_front();
            a.x    = pix_x;
            a.y    = pix_y;
            a.pix  = pix_addr;
            a.addr = addr_out;
            a.mode = mode_out;
            a.err  = mode_err;
            a.fs   = frame_start;
            a.fcnt = frame_cnt;
            a.hs   = hs;
            a.vs   = vs;
            a.bn   = blank_n;
            a.rgb  = {b_d, g_d, r_d};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s got x=%0d y=%0d pix=%0d addr=%h mode=%0d err=%b fs=%b fc=%0d hs=%b vs=%b bn=%b rgb=%h want x=%0d y=%0d pix=%0d addr=%h mode=%0d err=%b fs=%b fc=%0d hs=%b vs=%b bn=%b rgb=%h",
                         t, a.x, a.y, a.pix, a.addr, a.mode, a.err, a.fs, a.fcnt, a.hs, a.vs, a.bn, a.rgb,
                         e.x, e.y, e.pix, e.addr, e.mode, e.err, e.fs, e.fcnt, e.hs, e.vs, e.bn, e.rgb);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        mode_in = '0;
        drive_reset_pattern();
        repeat (3) begin
            @(posedge clk);
            #1;
            push_reset("por");
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_reset("release");
        run_phase(0, 425);

        // Mid-frame reset at h=5, v=2 takes effect immediately
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        mode_in = '0;
        drive_reset_pattern();
        push_reset("mid_rst");
        @(posedge clk);
        #1;
        push_reset("mid_rst_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_reset("mid_release");
        run_phase(1, 110);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        n_cmp++;
        if (fs_seen != 7) begin
            n_bad++;
            $display("FAIL frame_starts got %0d want 7", fs_seen);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
